// File: rtl/qif_synapse_driver.sv
// Synaptic current driver for the QIF neuron: buffers weighted spike events in a small FIFO
// and integrates them into a signed 8-bit current that decays exponentially toward zero.
module qif_synapse_driver #(
    parameter int DEPTH       = 4,
    parameter int DECAY_SHIFT = 3,
    parameter int TICK_DIV    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spk_valid,
    input  logic [7:0] spk_weight,
    output logic       spk_ready,
    input  logic       en,
    input  logic       clr_sat,
    output logic [7:0] I_syn,
    output logic       sat_flag,
    output logic       busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [0:0] {IDLE = 1'b0, DRIVE = 1'b1} state_t;

    logic signed [7:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     count_r, count_next_s;
    logic [TW-1:0]     tick_cnt_r;
    logic signed [7:0] isyn_r, isyn_next_s, idec_s, pop_w_s;
    logic [8:0]        sum_s;
    logic              sat_r, sat_set_s, busy_r, ready_r;
    logic              push_s, pop_s, tick_s;
    state_t            state_r, state_next_s;

    // Decay steps at least one LSB toward zero so small residuals still die out.
    function automatic logic signed [7:0] decay_step(input logic signed [7:0] v);
        logic signed [7:0] d;
        d = v >>> DECAY_SHIFT;
        if (d == 8'sd0 && v != 8'sd0) begin
            d = v[7] ? -8'sd1 : 8'sd1;
        end else begin
            d = d;
        end
        return v - d;
    endfunction

    // Returns {clamped, result}; the sum is formed at 10 bits so it cannot wrap.
    function automatic logic [8:0] add_clamp(input logic signed [7:0] a, input logic signed [7:0] b);
        logic signed [9:0] s;
        logic [8:0]        r;
        s = $signed({{2{a[7]}}, a}) + $signed({{2{b[7]}}, b});
        if (s > 10'sd127) begin
            r = {1'b1, 8'h7F};
        end else if (s < -10'sd128) begin
            r = {1'b1, 8'h80};
        end else begin
            r = {1'b0, s[7:0]};
        end
        return r;
    endfunction

    assign push_s    = spk_valid & ready_r;
    assign pop_s     = en & (count_r != {CW{1'b0}});
    assign tick_s    = (tick_cnt_r == TW'(TICK_DIV - 1));
    assign pop_w_s   = mem_r[rd_ptr_r];
    assign spk_ready = ready_r;
    assign I_syn     = isyn_r;
    assign sat_flag  = sat_r;
    assign busy      = busy_r;

    // FIFO occupancy after this edge.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Current update: decay first, then add the popped weight with clamping.
    always_comb begin
        idec_s      = tick_s ? decay_step(isyn_r) : isyn_r;
        sum_s       = add_clamp(idec_s, pop_w_s);
        isyn_next_s = idec_s;
        sat_set_s   = 1'b0;
        if (pop_s) begin
            isyn_next_s = sum_s[7:0];
            sat_set_s   = sum_s[8];
        end else begin
            isyn_next_s = idec_s;
            sat_set_s   = 1'b0;
        end
    end

    // Next-state logic for the IDLE/DRIVE activity tracker.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s && pop_w_s != 8'sd0) begin
                    state_next_s = DRIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRIVE: begin
                if (isyn_next_s == 8'sd0 && count_next_s == {CW{1'b0}}) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRIVE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'sd0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= spk_weight;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s < CW'(DEPTH));
        end
    end

    // Free-running decay tick counter, current register, sticky flag and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= {TW{1'b0}};
            isyn_r     <= 8'sd0;
            sat_r      <= 1'b0;
            state_r    <= IDLE;
            busy_r     <= 1'b0;
        end else begin
            tick_cnt_r <= tick_s ? {TW{1'b0}} : tick_cnt_r + TW'(1);
            isyn_r     <= isyn_next_s;
            if (sat_set_s) begin
                sat_r <= 1'b1;
            end else if (clr_sat) begin
                sat_r <= 1'b0;
            end
            state_r <= state_next_s;
            busy_r  <= (state_next_s == DRIVE);
        end
    end

endmodule

// File: tb/tb_qif_synapse_driver.sv
// Scoreboard bench for qif_synapse_driver: a cycle model queues expected outputs per edge,
// and directed scenarios add fixed-value checks on decay, saturation, backpressure and reset.
module tb_qif_synapse_driver;

    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              spk_valid = 1'b0;
    logic signed [7:0] spk_weight = 8'sd0;
    logic              en = 1'b0;
    logic              clr_sat = 1'b0;
    logic              spk_ready, sat_flag, busy;
    logic signed [7:0] I_syn;

    always #5 clk = ~clk;

    qif_synapse_driver #(.DEPTH(DEPTH), .DECAY_SHIFT(3), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .spk_valid(spk_valid), .spk_weight(spk_weight),
        .spk_ready(spk_ready), .en(en), .clr_sat(clr_sat), .I_syn(I_syn),
        .sat_flag(sat_flag), .busy(busy)
    );

    typedef struct { int isyn; int sat; int busy; int rdy; } exp_t;
    exp_t exp_q[$];
    int   mq[$];
    int   m_isyn, m_sat, m_busy, m_tick;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_model();
        mq.delete();
        exp_q.delete();
        m_isyn = 0; m_sat = 0; m_busy = 0; m_tick = 0;
    endtask

    // Reference behaviour for one rising edge using the inputs currently driven.
    task automatic model_step();
        int d, v, w0;
        bit push, pop, satset;
        exp_t e;
        push = spk_valid && (mq.size() < DEPTH);
        pop  = en && (mq.size() > 0);
        v = m_isyn;
        if (m_tick == TICK_DIV - 1) begin
            d = v >>> 3;
            if (d == 0 && v != 0) d = (v > 0) ? 1 : -1;
            v = v - d;
        end
        w0 = 0; satset = 0;
        if (pop) begin
            w0 = mq.pop_front();
            v = v + w0;
            if (v > 127) begin v = 127; satset = 1; end
            else if (v < -128) begin v = -128; satset = 1; end
        end
        m_isyn = v;
        if (satset) m_sat = 1;
        else if (clr_sat) m_sat = 0;
        if (push) mq.push_back(int'(spk_weight));
        if (m_busy == 0) begin
            if (pop && w0 != 0) m_busy = 1;
        end else if (m_isyn == 0 && mq.size() == 0) begin
            m_busy = 0;
        end
        m_tick = (m_tick + 1) % TICK_DIV;
        e.isyn = m_isyn; e.sat = m_sat; e.busy = m_busy; e.rdy = (mq.size() < DEPTH) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // One clock: queue the expectation, let the edge pass, compare just after it.
    task automatic cyc();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("sb_isyn", int'(I_syn), e.isyn);
        check_val("sb_sat", int'(sat_flag), e.sat);
        check_val("sb_busy", int'(busy), e.busy);
        check_val("sb_ready", int'(spk_ready), e.rdy);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            cyc();
            n++;
        end
        check_val("idle_busy", int'(busy), 0);
        check_val("idle_isyn", int'(I_syn), 0);
    endtask

    int dec_seq[4] = '{35, 31, 28, 25};
    int res_seq[3] = '{2, 1, 0};
    int bp_w[4]    = '{10, 20, -5, 7};
    int sgn;

    initial begin
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_isyn", int'(I_syn), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_sat", int'(sat_flag), 0);
        rst_n = 1'b1;
        reset_model();
        check_val("rst_ready", int'(spk_ready), 1);

        // Single event and its decay trajectory.
        en = 1'b1; spk_valid = 1'b1; spk_weight = 8'sd40;
        cyc();
        spk_valid = 1'b0;
        cyc();
        check_val("single_40", int'(I_syn), 40);
        check_val("single_busy", int'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            repeat (TICK_DIV) cyc();
            check_val("single_decay", int'(I_syn), dec_seq[i]);
        end
        wait_idle(400);

        // Small residuals step one LSB per tick toward zero.
        for (int k = 0; k < 2; k++) begin
            sgn = (k == 0) ? 1 : -1;
            spk_valid = 1'b1; spk_weight = 8'(3 * sgn);
            cyc();
            spk_valid = 1'b0;
            cyc();
            check_val("resid_start", int'(I_syn), 3 * sgn);
            for (int i = 0; i < 3; i++) begin
                repeat (TICK_DIV) cyc();
                check_val("resid_step", int'(I_syn), res_seq[i] * sgn);
            end
            check_val("resid_busy", int'(busy), 0);
        end

        // Decay and pop on the same edge.
        en = 1'b0; spk_valid = 1'b1; spk_weight = 8'sd64;
        cyc();
        spk_weight = 8'sd10;
        cyc();
        spk_valid = 1'b0;
        while (m_tick != TICK_DIV - 2) cyc();
        en = 1'b1;
        cyc();
        check_val("coin_64", int'(I_syn), 64);
        cyc();
        check_val("coin_66", int'(I_syn), 66);
        wait_idle(400);

        // Saturation high then low, then clear.
        spk_valid = 1'b1; spk_weight = 8'sd100;
        cyc();
        cyc();
        check_val("sat_100", int'(I_syn), 100);
        spk_weight = -8'sd128;
        cyc();
        check_val("sat_127", int'(I_syn), 127);
        check_val("sat_flag_hi", int'(sat_flag), 1);
        cyc();
        cyc();
        spk_valid = 1'b0;
        cyc();
        check_val("sat_m128", int'(I_syn), -128);
        check_val("sat_flag_lo", int'(sat_flag), 1);
        clr_sat = 1'b1;
        cyc();
        clr_sat = 1'b0;
        check_val("sat_clr", int'(sat_flag), 0);
        wait_idle(1000);

        // Backpressure with en low, then drain in order.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            spk_valid = 1'b1; spk_weight = 8'(bp_w[i]);
            cyc();
        end
        check_val("bp_full", int'(spk_ready), 0);
        spk_weight = 8'sd99;
        cyc();
        cyc();
        check_val("bp_held", int'(spk_ready), 0);
        en = 1'b1;
        cyc();
        check_val("bp_first", int'(I_syn), 10);
        check_val("bp_ready_back", int'(spk_ready), 1);
        cyc();
        spk_valid = 1'b0;
        repeat (8) cyc();
        wait_idle(1000);

        // Reset mid-DRIVE with three queued events.
        spk_valid = 1'b1; spk_weight = 8'sd127;
        cyc();
        cyc();
        spk_valid = 1'b0;
        cyc();
        en = 1'b0; spk_valid = 1'b1;
        spk_weight = 8'sd11; cyc();
        spk_weight = 8'sd22; cyc();
        spk_weight = 8'sd33; cyc();
        spk_valid = 1'b0;
        check_val("pre_rst_busy", int'(busy), 1);
        check_val("pre_rst_sat", int'(sat_flag), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_isyn", int'(I_syn), 0);
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_sat", int'(sat_flag), 0);
        reset_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
        check_val("post_rst_ready", int'(spk_ready), 1);
        en = 1'b1;
        repeat (20) cyc();
        check_val("post_rst_isyn", int'(I_syn), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
